button_debounce: RTL and testbench

//  Input-side counterpart to the board LED drivers: conditions one raw push-button pin on the 100 MHz CLK domain.

---
 rtl/button_debounce.sv | 125 ++++++++++++
 tb/tb_button_debounce.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM, clean level plus press/release strobes.
// Optional long-press strobe is built only when BUTTON_LONG_PRESS_EN is defined.
//
//   state | meaning
//   REL   | released, idle
//   PCHK  | pin reads pressed, counting stable cycles before accepting
//   PRS   | pressed, idle
//   RCHK  | pin reads released, counting stable cycles before accepting
module button_debounce #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic PRESSED,
  output logic PRESS_PULSE,
  output logic RELEASE_PULSE,
  output logic LONG_PULSE
);

  localparam int MAX_CYC = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ? DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {REL, PCHK, PRS, RCHK} state_t;

  state_t        state;
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          btn_norm;
  logic          act;

  // Inverting before the first flop keeps the synchroniser reset value equal to "released".
  assign btn_norm = BTN ^ ACTIVE_LOW;
  assign act      = sync[1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync          <= 2'b00;
      state         <= REL;
      cnt           <= '0;
      PRESSED       <= 1'b0;
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
    end else begin
      sync          <= {sync[0], btn_norm};
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      case (state)
        REL: begin
          if (act) begin
            state <= PCHK;
            cnt   <= '0;
          end
        end
        PCHK: begin
          if (!act) begin
            state <= REL;
          end else if (cnt == DEB_LAST) begin
            state       <= PRS;
            PRESSED     <= 1'b1;
            PRESS_PULSE <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRS: begin
          if (!act) begin
            state <= RCHK;
            cnt   <= '0;
          end
        end
        RCHK: begin
          if (act) begin
            state <= PRS;
          end else if (cnt == DEB_LAST) begin
            state         <= REL;
            PRESSED       <= 1'b0;
            RELEASE_PULSE <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= REL;
      endcase
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);

  logic [CW-1:0] lcnt;
  logic          long_done;
  logic          press_entry;

  assign press_entry = (state == PCHK) && act && (cnt == DEB_LAST);

  // long_done limits the strobe to one per accepted press once lcnt has saturated.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lcnt       <= '0;
      long_done  <= 1'b1;
      LONG_PULSE <= 1'b0;
    end else begin
      LONG_PULSE <= 1'b0;
      if (press_entry) begin
        lcnt      <= '0;
        long_done <= 1'b0;
      end else if (state == PRS || state == RCHK) begin
        if (lcnt != LONG_LAST) begin
          lcnt <= lcnt + 1'b1;
        end else if (!long_done) begin
          LONG_PULSE <= 1'b1;
          long_done  <= 1'b1;
        end
      end
    end
  end
`else
  assign LONG_PULSE = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios with literal expectations, then random pin activity
// checked every cycle against a window-based model of the accept rule.
module tb_button_debounce;
  localparam int D    = 4;
  localparam int L    = 10;
  localparam int NMAX = 16384;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic BTN = 1'b1;
  logic PRESSED, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  button_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(L),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .BTN(BTN),
    .PRESSED(PRESSED),
    .PRESS_PULSE(PRESS_PULSE),
    .RELEASE_PULSE(RELEASE_PULSE),
    .LONG_PULSE(LONG_PULSE)
  );

  task automatic check(input string name, input logic act_v, input logic exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act_v, exp_v);
    end
  endtask

  task automatic check_int(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act_v, exp_v);
    end
  endtask

  // Model: a change is accepted at edge e when the pin samples of edges e-2-D .. e-2
  // all show the opposite of the current debounced level. Reset forces those samples released.
  bit samp [0:NMAX-1];
  int e = -1;
  int press_edge = -1;
  bit deb = 1'b0;
  bit exp_press = 1'b0;
  bit exp_rel = 1'b0;
  bit exp_long = 1'b0;
  bit model_valid = 1'b0;

  always @(posedge CLK) begin
    bit all_new;
    e++;
    exp_press = 1'b0;
    exp_rel   = 1'b0;
    exp_long  = 1'b0;
    if (RST) begin
      samp[e] = 1'b0;
      if (e > 0) samp[e-1] = 1'b0;
      deb = 1'b0;
      press_edge = -1;
    end else begin
      samp[e] = (BTN == 1'b0);
`ifdef BUTTON_LONG_PRESS_EN
      if (deb && press_edge >= 0 && (e - press_edge) == L) exp_long = 1'b1;
`endif
      if (e - 2 - D >= 0) begin
        all_new = 1'b1;
        for (int k = 0; k <= D; k++)
          if (samp[e-2-k] == deb) all_new = 1'b0;
        if (all_new) begin
          deb = !deb;
          if (deb) begin
            exp_press  = 1'b1;
            press_edge = e;
          end else begin
            exp_rel    = 1'b1;
            press_edge = -1;
          end
        end
      end
    end
    model_valid = 1'b1;
  end

  always @(negedge CLK) begin
    if (model_valid) begin
      check("pressed", PRESSED, deb);
      check("press_pulse", PRESS_PULSE, exp_press);
      check("release_pulse", RELEASE_PULSE, exp_rel);
      check("long_pulse", LONG_PULSE, exp_long);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_a;
    int cnt_b;
    int n;
    logic long_exp;
`ifdef BUTTON_LONG_PRESS_EN
    long_exp = 1'b1;
`else
    long_exp = 1'b0;
`endif

    // reset with pin released, then idle
    RST = 1'b1; BTN = 1'b1;
    tick(); tick();
    check("rst_pressed", PRESSED, 1'b0);
    check("rst_press_pulse", PRESS_PULSE, 1'b0);
    check("rst_release_pulse", RELEASE_PULSE, 1'b0);
    check("rst_long_pulse", LONG_PULSE, 1'b0);
    RST = 1'b0;
    cnt_a = 0;
    repeat (20) begin
      tick();
      cnt_a += int'(PRESS_PULSE) + int'(RELEASE_PULSE) + int'(LONG_PULSE);
    end
    check_int("idle_strobes", cnt_a, 0);

    // short low glitch rejected
    BTN = 1'b0;
    ticks(3);
    BTN = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    repeat (10) begin
      tick();
      cnt_a += int'(PRESS_PULSE);
      cnt_b += int'(PRESSED);
    end
    check_int("glitch_press_pulses", cnt_a, 0);
    check_int("glitch_pressed_cycles", cnt_b, 0);

    // clean press: strobe visible after edge N+6
    BTN = 1'b0;
    ticks(6);
    check("press_early_pulse", PRESS_PULSE, 1'b0);
    check("press_early_level", PRESSED, 1'b0);
    tick();
    check("press_pulse_n6", PRESS_PULSE, 1'b1);
    check("press_level_n6", PRESSED, 1'b1);
    check("model_press_n6", exp_press, 1'b1);
    tick();
    check("press_pulse_one_cycle", PRESS_PULSE, 1'b0);

    // long press: strobe 10 cycles after the press strobe (now 1 cycle after it)
    ticks(8);
    check("long_early", LONG_PULSE, 1'b0);
    tick();
    check("long_at_10", LONG_PULSE, long_exp);
    check("model_long_at_10", exp_long, long_exp);
    cnt_a = 0;
    repeat (20) begin
      tick();
      cnt_a += int'(LONG_PULSE);
    end
    check_int("long_single", cnt_a, 0);
    check("held_level", PRESSED, 1'b1);

    // release with bounce 1/0/1, last transition at edge M
    BTN = 1'b1; tick();
    BTN = 1'b0; tick();
    BTN = 1'b1;
    ticks(6);
    check("release_early_pulse", RELEASE_PULSE, 1'b0);
    check("release_early_level", PRESSED, 1'b1);
    tick();
    check("release_pulse_m6", RELEASE_PULSE, 1'b1);
    check("release_level_m6", PRESSED, 1'b0);
    check("model_release_m6", exp_rel, 1'b1);
    ticks(5);

    // reset during held press
    BTN = 1'b0;
    ticks(10);
    check("held_before_rst", PRESSED, 1'b1);
    RST = 1'b1;
    tick();
    check("rst_held_level", PRESSED, 1'b0);
    check("rst_held_no_release", RELEASE_PULSE, 1'b0);
    RST = 1'b0;
    ticks(6);
    check("post_rst_early", PRESS_PULSE, 1'b0);
    tick();
    check("post_rst_press", PRESS_PULSE, 1'b1);
    ticks(3);

    // random pin activity with occasional resets
    repeat (300) begin
      BTN = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 14);
      for (int i = 0; i < n; i++) begin
        RST = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    RST = 1'b0;
    BTN = 1'b1;
    ticks(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
